// File: rtl/up_down_counter_lim_if.sv
// up_down_counter_lim_if
//  Groups the control and status signals of up_down_counter_lim.
//  master : drives load/data/enable/dir/sat_mode/limit, observes count/tc/at_max/at_zero
//  slave  : the counter itself
//  Parameter WIDTH must match the counter's WIDTH.
interface up_down_counter_lim_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] data;
  logic             enable;
  logic             dir;
  logic             sat_mode;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             at_max;
  logic             at_zero;

  modport master (
    output load, data, enable, dir, sat_mode, limit,
    input  count, tc, at_max, at_zero
  );

  modport slave (
    input  load, data, enable, dir, sat_mode, limit,
    output count, tc, at_max, at_zero
  );
endinterface

// File: rtl/up_down_counter_lim.sv
// up_down_counter_lim
//  Up/down counter with parallel load, runtime upper limit (range 0..limit),
//  wrap or saturate at the bounds, and a registered one-cycle terminal-count pulse.
//  Ports:
//    clk    : clock, all updates on posedge
//    reset  : synchronous, active-high
//    bus    : up_down_counter_lim_if.slave
//             load/data  - parallel load (clamped to limit)
//             enable     - count enable
//             dir        - 1 up, 0 down
//             sat_mode   - 1 saturate, 0 wrap
//             limit      - upper bound
//             count      - registered count
//             tc         - registered terminal-count pulse
//             at_max     - count >= limit (combinational)
//             at_zero    - count == 0 (combinational)
//  Optional feature macro: COUNTER_PRESCALE_EN
//    When defined, a step happens only on every PRESCALE-th enabled cycle.
module up_down_counter_lim #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input logic                 clk,
  input logic                 reset,
  up_down_counter_lim_if.slave bus
);

  logic [WIDTH-1:0] cnt_q;
  logic             tc_q;
  logic [WIDTH-1:0] nxt;
  logic             nxt_tc;
  logic             step;

`ifdef COUNTER_PRESCALE_EN
  localparam int PS_W = $clog2(PRESCALE);
  logic [PS_W-1:0] ps_q;
  logic            ps_wrap;

  assign ps_wrap = (ps_q == PS_W'(PRESCALE - 1));
  assign step    = bus.enable && ps_wrap;

  // Load wins over enable, so a load also restarts the step spacing.
  always_ff @(posedge clk) begin
    if (reset || bus.load)
      ps_q <= '0;
    else if (bus.enable)
      ps_q <= ps_wrap ? '0 : ps_q + 1'b1;
  end
`else
  assign step = bus.enable;
`endif

  // Next value for a qualified step.
  always_comb begin
    nxt    = cnt_q;
    nxt_tc = 1'b0;
    if (bus.limit == '0) begin
      // Degenerate range: every step lands on 0 and is a boundary step,
      // even when stepping down from a stale count above the new limit.
      nxt    = '0;
      nxt_tc = 1'b1;
    end else if (bus.dir) begin
      if (cnt_q >= bus.limit) begin
        nxt    = bus.sat_mode ? bus.limit : '0;
        nxt_tc = 1'b1;
      end else begin
        nxt = cnt_q + 1'b1;
      end
    end else begin
      if (cnt_q == '0) begin
        nxt    = bus.sat_mode ? '0 : bus.limit;
        nxt_tc = 1'b1;
      end else if (cnt_q > bus.limit) begin
        // Limit was lowered below the count: pull back into range.
        nxt = bus.limit;
      end else begin
        nxt = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else if (bus.load) begin
      cnt_q <= (bus.data > bus.limit) ? bus.limit : bus.data;
      tc_q  <= 1'b0;
    end else if (step) begin
      cnt_q <= nxt;
      tc_q  <= nxt_tc;
    end else begin
      tc_q  <= 1'b0;
    end
  end

  assign bus.count   = cnt_q;
  assign bus.tc      = tc_q;
  assign bus.at_max  = (cnt_q >= bus.limit);
  assign bus.at_zero = (cnt_q == '0);

endmodule
